// File: rtl/data_mem_resp.sv
// Word-organised data memory behind a request/grant/rvalid port.
// One access is in flight at a time. A granted request is captured, held
// for WAIT_CYCLES extra cycles, then answered with a single rvalid cycle.
// Misaligned or empty-byte-enable requests are answered with an error and
// never touch the storage.
module data_mem_resp #(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int WAIT_CYCLES    = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      data_req_i,
    input  logic                      data_we_i,
    input  logic [3:0]                data_be_i,
    input  logic [MEM_ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0]     data_wdata_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    output logic [DATA_WIDTH-1:0]     data_rdata_o,
    output logic                      data_err_o
);

    localparam int IDX_W = MEM_ADDR_WIDTH - 2;
    localparam int DEPTH = 2 ** IDX_W;
    // Counter preload; unused when there are no wait states.
    localparam logic [2:0] CNT_INIT = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                    state_r;
    state_e                    state_nxt_s;
    logic [2:0]                cnt_r;
    logic [2:0]                cnt_nxt_s;
    logic                      gnt_s;
    logic                      enter_resp_s;

    logic [MEM_ADDR_WIDTH-1:0] addr_r;
    logic                      we_r;
    logic [3:0]                be_r;
    logic [DATA_WIDTH-1:0]     wdata_r;

    logic [MEM_ADDR_WIDTH-1:0] acc_addr_s;
    logic                      acc_we_s;
    logic [3:0]                acc_be_s;
    logic [DATA_WIDTH-1:0]     acc_wdata_s;
    logic [IDX_W-1:0]          acc_idx_s;
    logic                      acc_ok_s;
    logic                      mem_we_s;

    logic                      rvalid_r;
    logic                      err_r;
    logic [DATA_WIDTH-1:0]     rdata_r;

    logic [DATA_WIDTH-1:0]     mem_r [DEPTH];

    // Merge new store data into an existing word under byte enables.
    function automatic logic [DATA_WIDTH-1:0] be_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [3:0]            be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    // FSM state and wait counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state, grant and response-entry decode; grant is held low in reset.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        gnt_s        = 1'b0;
        enter_resp_s = 1'b0;
        case (state_r)
            IDLE: begin
                gnt_s = data_req_i & rst_ni;
                if (gnt_s) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt_s  = RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_nxt_s = WAIT;
                        cnt_nxt_s   = CNT_INIT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 3'd0) begin
                    state_nxt_s  = RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - 3'd1;
                end
            end
            RESP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 3'd0;
            end
        endcase
    end

    // Capture the request fields on the grant cycle only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_r  <= '0;
            we_r    <= 1'b0;
            be_r    <= 4'd0;
            wdata_r <= '0;
        end else if (gnt_s) begin
            addr_r  <= data_addr_i;
            we_r    <= data_we_i;
            be_r    <= data_be_i;
            wdata_r <= data_wdata_i;
        end
    end

    // Fields used for the access: with no wait states the grant edge is also
    // the access edge, so the values being captured are used directly.
    always_comb begin
        if (gnt_s) begin
            acc_addr_s  = data_addr_i;
            acc_we_s    = data_we_i;
            acc_be_s    = data_be_i;
            acc_wdata_s = data_wdata_i;
        end else begin
            acc_addr_s  = addr_r;
            acc_we_s    = we_r;
            acc_be_s    = be_r;
            acc_wdata_s = wdata_r;
        end
    end

    assign acc_idx_s = acc_addr_s[MEM_ADDR_WIDTH-1:2];
    assign acc_ok_s  = (acc_addr_s[1:0] == 2'b00) && (acc_be_s != 4'b0000);
    assign mem_we_s  = enter_resp_s & acc_we_s & acc_ok_s;

    // Storage write port; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem_r[acc_idx_s] <= be_merge(mem_r[acc_idx_s], acc_wdata_s, acc_be_s);
        end
    end

    // Response registers: loaded on the edge entering RESP, cleared otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
            rdata_r  <= '0;
        end else if (enter_resp_s) begin
            rvalid_r <= 1'b1;
            err_r    <= ~acc_ok_s;
            rdata_r  <= (acc_ok_s && !acc_we_s) ? mem_r[acc_idx_s] : '0;
        end else begin
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
            rdata_r  <= '0;
        end
    end

    assign data_gnt_o    = gnt_s;
    assign data_rvalid_o = rvalid_r;
    assign data_err_o    = err_r;
    assign data_rdata_o  = rdata_r;

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: three instances (0, 1 and 3 wait states) share
// clock and reset. Expected responses are queued at grant time and popped
// by a monitor when rvalid appears.
`timescale 1ns/1ps
module tb_data_mem_resp;

    logic              clk;
    logic              rst_n;
    logic [2:0]        req_v;
    logic [2:0]        we_v;
    logic [2:0][3:0]   be_v;
    logic [2:0][9:0]   addr_v;
    logic [2:0][31:0]  wdata_v;
    wire  [2:0]        gnt_v;
    wire  [2:0]        rvalid_v;
    wire  [2:0]        err_v;
    wire  [2:0][31:0]  rdata_v;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    typedef struct {
        int          dev;
        logic [31:0] rdata;
        logic        err;
        int          gcyc;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int          dev;
        logic        we;
        logic [3:0]  be;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] xrdata;
        logic        xerr;
    } vec_t;
    vec_t vecs[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WC = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        data_mem_resp #(
            .MEM_ADDR_WIDTH(10),
            .DATA_WIDTH    (32),
            .WAIT_CYCLES   (WC)
        ) u_dut (
            .clk_i        (clk),
            .rst_ni       (rst_n),
            .data_req_i   (req_v[g]),
            .data_we_i    (we_v[g]),
            .data_be_i    (be_v[g]),
            .data_addr_i  (addr_v[g]),
            .data_wdata_i (wdata_v[g]),
            .data_gnt_o   (gnt_v[g]),
            .data_rvalid_o(rvalid_v[g]),
            .data_rdata_o (rdata_v[g]),
            .data_err_o   (err_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wcyc(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rvalid_v[d]) begin
                if (sbq.size() == 0 || sbq[0].dev != d) begin
                    chk("unexpected_rvalid", {31'd0, rvalid_v[d]}, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("rdata", rdata_v[d], e.rdata);
                    chk("err", {31'd0, err_v[d]}, {31'd0, e.err});
                    chk("latency", cyc - e.gcyc, wcyc(d) + 1);
                end
            end else begin
                chk("idle_rdata", rdata_v[d], 32'd0);
                chk("idle_err", {31'd0, err_v[d]}, 32'd0);
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sbq.size() > 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        if (sbq.size() > 0) begin
            chk("resp_timeout", sbq.size(), 32'd0);
            sbq.delete();
        end
    endtask

    task automatic access(input int d, input logic we, input logic [3:0] be, input logic [9:0] addr,
                          input logic [31:0] wdata, input logic [31:0] xr, input logic xe);
        int n = 0;
        @(negedge clk);
        we_v[d] = we; be_v[d] = be; addr_v[d] = addr; wdata_v[d] = wdata; req_v[d] = 1'b1;
        #1;
        while (!gnt_v[d] && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("grant", {31'd0, gnt_v[d]}, 32'd1);
        if (gnt_v[d]) begin
            exp_t e;
            e.dev = d; e.rdata = xr; e.err = xe; e.gcyc = cyc;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        req_v[d] = 1'b0;
        we_v[d] = 1'($urandom_range(0, 1));
        be_v[d] = 4'($urandom_range(0, 15));
        addr_v[d] = 10'($urandom_range(0, 1023));
        wdata_v[d] = $urandom;
        drain();
    endtask

    // Hold req high: only the IDLE-cycle request may be captured.
    task automatic hold_req(input int d);
        logic [9:0]  gaddr[$];
        logic [31:0] gdata[$];
        int last = -1;
        int ncyc = 3 * (wcyc(d) + 2) + 1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            req_v[d] = 1'b1; we_v[d] = 1'b1; be_v[d] = 4'hF;
            addr_v[d] = 10'h100 + 10'(4 * i);
            wdata_v[d] = 32'h5000_0000 + 32'(i);
            #1;
            if (gnt_v[d]) begin
                exp_t e;
                if (last >= 0) chk("grant_spacing", cyc - last, wcyc(d) + 2);
                last = cyc;
                e.dev = d; e.rdata = 32'd0; e.err = 1'b0; e.gcyc = cyc;
                sbq.push_back(e);
                gaddr.push_back(addr_v[d]);
                gdata.push_back(wdata_v[d]);
            end
        end
        @(negedge clk);
        req_v[d] = 1'b0;
        drain();
        chk("grant_count", gaddr.size(), 32'd4);
        for (int j = 0; j < gaddr.size(); j++) begin
            access(d, 1'b0, 4'hF, gaddr[j], 32'd0, gdata[j], 1'b0);
        end
        access(d, 1'b0, 4'hF, 10'h104, 32'd0, 32'h7777_7777, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req_v = 3'b111; we_v = 3'b000; be_v = '0; addr_v = '0; wdata_v = '0;
        // {dev, we, be, addr, wdata, expected rdata, expected err}
        vecs.push_back('{1, 1'b1, 4'hF, 10'h010, 32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back('{1, 1'b0, 4'hF, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1, 1'b1, 4'hF, 10'h020, 32'h11223344, 32'h0,        1'b0});
        vecs.push_back('{1, 1'b1, 4'h4, 10'h020, 32'h00AA0000, 32'h0,        1'b0});
        vecs.push_back('{1, 1'b0, 4'hF, 10'h020, 32'h0,        32'h11AA3344, 1'b0});
        vecs.push_back('{1, 1'b0, 4'h1, 10'h020, 32'h0,        32'h11AA3344, 1'b0});
        vecs.push_back('{1, 1'b1, 4'h9, 10'h020, 32'hFF0000EE, 32'h0,        1'b0});
        vecs.push_back('{1, 1'b0, 4'hF, 10'h020, 32'h0,        32'hFFAA33EE, 1'b0});
        vecs.push_back('{1, 1'b0, 4'hF, 10'h013, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1, 1'b0, 4'hF, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1, 1'b1, 4'h0, 10'h010, 32'hFFFFFFFF, 32'h0,        1'b1});
        vecs.push_back('{1, 1'b1, 4'hF, 10'h012, 32'hFFFFFFFF, 32'h0,        1'b1});
        vecs.push_back('{1, 1'b0, 4'hF, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1, 1'b1, 4'hF, 10'h3FC, 32'hCAFEF00D, 32'h0,        1'b0});
        vecs.push_back('{1, 1'b1, 4'hF, 10'h000, 32'hA5A5A5A5, 32'h0,        1'b0});
        vecs.push_back('{1, 1'b0, 4'hF, 10'h3FC, 32'h0,        32'hCAFEF00D, 1'b0});
        vecs.push_back('{1, 1'b0, 4'hF, 10'h000, 32'h0,        32'hA5A5A5A5, 1'b0});
        vecs.push_back('{1, 1'b0, 4'h0, 10'h3FC, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{0, 1'b1, 4'hF, 10'h040, 32'h01020304, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b1, 4'h3, 10'h040, 32'h0000BBAA, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b0, 4'hF, 10'h040, 32'h0,        32'h0102BBAA, 1'b0});
        vecs.push_back('{0, 1'b0, 4'hF, 10'h041, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{2, 1'b1, 4'hF, 10'h3FC, 32'h89ABCDEF, 32'h0,        1'b0});
        vecs.push_back('{2, 1'b1, 4'h8, 10'h3FC, 32'h55000000, 32'h0,        1'b0});
        vecs.push_back('{2, 1'b0, 4'hF, 10'h3FC, 32'h0,        32'h55ABCDEF, 1'b0});
        vecs.push_back('{2, 1'b0, 4'hF, 10'h3FE, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{0, 1'b1, 4'hF, 10'h104, 32'h77777777, 32'h0,        1'b0});
        vecs.push_back('{2, 1'b1, 4'hF, 10'h104, 32'h77777777, 32'h0,        1'b0});

        // Reset state: grant stays low even with req asserted.
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset_gnt", {31'd0, gnt_v[d]}, 32'd0);
            chk("reset_rvalid", {31'd0, rvalid_v[d]}, 32'd0);
        end
        req_v = 3'b000;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            access(vecs[i].dev, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata,
                   vecs[i].xrdata, vecs[i].xerr);
        end

        hold_req(0);
        hold_req(2);

        // Reset during WAIT aborts a pending store.
        access(1, 1'b1, 4'hF, 10'h3FC, 32'h12345678, 32'h0, 1'b0);
        @(negedge clk);
        we_v[1] = 1'b1; be_v[1] = 4'hF; addr_v[1] = 10'h3FC; wdata_v[1] = 32'hFFFFFFFF;
        req_v[1] = 1'b1;
        #1;
        chk("abort_grant", {31'd0, gnt_v[1]}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_gnt", {31'd0, gnt_v[1]}, 32'd0);
        chk("abort_rvalid", {31'd0, rvalid_v[1]}, 32'd0);
        chk("abort_err", {31'd0, err_v[1]}, 32'd0);
        chk("abort_rdata", rdata_v[1], 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_hold_gnt", {31'd0, gnt_v[1]}, 32'd0);
        req_v = 3'b000;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        access(1, 1'b0, 4'hF, 10'h3FC, 32'h0, 32'h12345678, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 10, byte-address width of the data port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; only 32 is supported.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, number of extra wait states per access; legal range 0..7.
REQ-004 SHALL have port clk_i, input, 1 bit, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port data_req_i, input, 1 bit, request from the core LIS path.
REQ-007 SHALL have port data_we_i, input, 1 bit; 1 = store, 0 = load.
REQ-008 SHALL have port data_be_i, input, 4 bits, byte enables; bit n covers wdata[8n+7:8n].
REQ-009 SHALL have port data_addr_i, input, MEM_ADDR_WIDTH bits, byte address.
REQ-010 SHALL have port data_wdata_i, input, DATA_WIDTH bits, store data.
REQ-011 SHALL have port data_gnt_o, output, 1 bit, request accepted; combinational.
REQ-012 SHALL have port data_rvalid_o, output, 1 bit, one-cycle response strobe.
REQ-013 SHALL have port data_rdata_o, output, DATA_WIDTH bits, load data, valid only while data_rvalid_o=1.
REQ-014 SHALL have port data_err_o, output, 1 bit, error flag, valid only while data_rvalid_o=1.

Function
REQ-015 SHALL contain 2^(MEM_ADDR_WIDTH-2) words of storage indexed by data_addr_i[MEM_ADDR_WIDTH-1:2].
REQ-016 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-017 In IDLE, data_gnt_o SHALL equal data_req_i; in WAIT and RESP, data_gnt_o SHALL be 0.
REQ-018 On an IDLE cycle with data_req_i=1, the block SHALL register addr, we, be and wdata.
REQ-019 From that same IDLE cycle, the FSM SHALL go to RESP if WAIT_CYCLES=0, else to WAIT with wait counter loaded to WAIT_CYCLES-1.
REQ-020 In WAIT, the counter SHALL decrement each cycle; at counter 0 the FSM SHALL go to RESP.
REQ-021 Latency from the grant cycle to the rvalid cycle SHALL be exactly WAIT_CYCLES+1 clock cycles.
REQ-022 The memory access SHALL occur on the clock edge entering RESP, using only the registered request fields.
REQ-023 For a store, only bytes with be=1 SHALL be written, and data_rdata_o SHALL be 0 in RESP.
REQ-024 For a load, data_rdata_o SHALL be the full addressed word, independent of be; byte extraction belongs to the core.
REQ-025 If registered addr[1:0]!=0 or be=4'b0000, the block SHALL perform no memory access and SHALL set data_err_o=1 with data_rdata_o=0 in RESP.
REQ-026 RESP SHALL last exactly one cycle with data_rvalid_o=1, then the FSM SHALL return to IDLE.
REQ-027 A new request SHALL NOT be granted before IDLE is re-entered; maximum throughput is one access per WAIT_CYCLES+2 cycles.
REQ-028 Outside RESP, data_rvalid_o, data_err_o and data_rdata_o SHALL be 0.
REQ-029 Changes on request inputs while in WAIT or RESP SHALL have no effect.
REQ-030 The highest word index SHALL be accessible, and the address SHALL NOT wrap into other words.

Reset
REQ-031 While rst_ni=0, the FSM SHALL be IDLE and the counter and registered request fields SHALL be 0.
REQ-032 While rst_ni=0, data_rvalid_o, data_err_o and data_rdata_o SHALL be 0, and data_gnt_o SHALL be 0 regardless of data_req_i.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 Reset asserted in WAIT SHALL abort the access; a pending store SHALL leave memory unmodified, and no rvalid SHALL follow.

Verification
REQ-035 WAIT_CYCLES=1: store addr 0x010, be=4'hF, wdata=0xDEADBEEF -> gnt same cycle, rvalid 2 cycles later with err=0 and rdata=0; then load 0x010 -> rdata=0xDEADBEEF.
REQ-036 Partial store be=4'b0100, wdata=0x00AA0000 to word holding 0x11223344 -> load returns 0x11AA3344.
REQ-037 Load addr 0x013 -> rvalid with err=1 and rdata=0; memory unchanged; store with be=0 -> err=1.
REQ-038 WAIT_CYCLES=0 and 3: hold req=1 continuously -> grants spaced 2 and 5 cycles apart, one rvalid per grant, and the request presented during WAIT/RESP is not captured.
REQ-039 Store to 0x3FC of 0x12345678, then rst_ni low during WAIT of a store of 0xFFFFFFFF to 0x3FC -> all outputs 0 immediately, no rvalid; after release, load 0x3FC returns 0x12345678.
